// File: rtl/lookupflow_req.sv
// -----------------------------------------------------------------------------
// lookupflow_req
//
// Initiator side of the of_lookup request/ack interface. Watches one port's
// 8-bit RX byte stream, pulls the source MAC, ethertype, source IP and
// destination IP out of each Ethernet/IPv4 frame, builds a 116-bit lookup key,
// fires a one-cycle lookup request, waits (bounded) for the ack, and presents
// the forwarding decision on a valid/ready result port.
//
// Handshake rules: a result transfer happens on a rising sys_clk edge where
// res_valid && res_ready are both high. Once res_valid is raised it stays high
// and res_fwd_port/res_drop/res_timeout stay stable until that transfer;
// res_valid drops in the cycle after it. The request side is a single-cycle
// pulse (of_lookup_req) with no ready; the responder answers with a
// single-cycle of_lookup_ack carrying of_lookup_err/of_lookup_fwd_port.
//
// Parameters:
//   PORT_ID    ingress port number, placed in key bits [115:112]
//   TIMEOUT    cycles to wait for of_lookup_ack after the request (1..255)
//   FLOOD_MASK forwarding mask returned for non-IPv4 frames
//
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   in_valid/in_sof/in_eof     byte stream qualifiers
//   in_data[7:0]               frame byte, byte 0 = first DA byte
//   of_lookup_req              one-cycle lookup request
//   of_lookup_data[115:0]      key {port, src MAC, src IP, dst IP}
//   of_lookup_ack/err/fwd_port lookup answer
//   res_valid/res_ready        result handshake
//   res_fwd_port/drop/timeout  forwarding decision
//   dbg_state[2:0]             current FSM state (0 IDLE, 1 PARSE, 2 REQ,
//                              3 WAIT, 4 RESULT)
//
// Optional build macro LOOKUPFLOW_REQ_STATS_EN adds saturating 16-bit
// counters stat_lookup, stat_err, stat_timeout, stat_overrun.
// -----------------------------------------------------------------------------
module lookupflow_req #(
  parameter logic [3:0] PORT_ID    = 4'h0,
  parameter int         TIMEOUT    = 16,
  parameter logic [3:0] FLOOD_MASK = 4'b1111
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic         in_eof,
  input  logic [7:0]   in_data,
  output logic         of_lookup_req,
  output logic [115:0] of_lookup_data,
  input  logic         of_lookup_ack,
  input  logic         of_lookup_err,
  input  logic [3:0]   of_lookup_fwd_port,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [3:0]   res_fwd_port,
  output logic         res_drop,
  output logic         res_timeout,
`ifdef LOOKUPFLOW_REQ_STATS_EN
  output logic [15:0]  stat_lookup,
  output logic [15:0]  stat_err,
  output logic [15:0]  stat_timeout,
  output logic [15:0]  stat_overrun,
`endif
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PARSE  = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  localparam logic [7:0]  TMO_LOAD  = 8'(TIMEOUT);
  localparam logic [10:0] CNT_MAX   = 11'h7FF;
  // Index of the last byte of the dst IP field; a frame whose eof byte has a
  // smaller index is too short to carry a complete key.
  localparam logic [10:0] LAST_KEY_BYTE = 11'd33;
  localparam logic [15:0] ETYPE_IPV4    = 16'h0800;

  state_t        state_q, state_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [47:0]   mac_q, mac_d;
  logic [15:0]   etype_q, etype_d;
  logic [31:0]   sip_q, sip_d;
  logic [31:0]   dip_q, dip_d;
  logic [115:0]  key_q, key_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [3:0]    fwd_q, fwd_d;
  logic          drop_q, drop_d;
  logic          tout_q, tout_d;

  // Bytes are only taken while a frame is being parsed (or starts in IDLE);
  // frames that arrive while a lookup is in flight never touch the capture
  // registers, so the key of the frame in flight cannot be corrupted.
  logic accept_byte;
  assign accept_byte = in_valid &&
                       (((state_q == ST_IDLE) && in_sof) || (state_q == ST_PARSE));

  // ---------------------------------------------------------------------------
  // Byte counter and header field capture
  // cnt_q holds the index of the byte currently on in_data (the sof byte is
  // index 0 and loads the counter with 1 for the following byte).
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    mac_d   = mac_q;
    etype_d = etype_q;
    sip_d   = sip_q;
    dip_d   = dip_q;
    if (accept_byte) begin
      if (in_sof) begin
        cnt_d = 11'd1;
      end else begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 11'd1;
        end
        // Fields arrive MSB first, so each one is a left shift register.
        if ((cnt_q >= 11'd6) && (cnt_q <= 11'd11)) begin
          mac_d = {mac_q[39:0], in_data};
        end
        if ((cnt_q >= 11'd12) && (cnt_q <= 11'd13)) begin
          etype_d = {etype_q[7:0], in_data};
        end
        if ((cnt_q >= 11'd26) && (cnt_q <= 11'd29)) begin
          sip_d = {sip_q[23:0], in_data};
        end
        if ((cnt_q >= 11'd30) && (cnt_q <= 11'd33)) begin
          dip_d = {dip_q[23:0], in_data};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q   <= '0;
      mac_q   <= '0;
      etype_q <= '0;
      sip_q   <= '0;
      dip_q   <= '0;
      key_q   <= '0;
      tmo_q   <= '0;
      fwd_q   <= '0;
      drop_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mac_q   <= mac_d;
      etype_q <= etype_d;
      sip_q   <= sip_d;
      dip_q   <= dip_d;
      key_q   <= key_d;
      tmo_q   <= tmo_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
      tout_q  <= tout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, also computing the values latched for REQ and RESULT.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    tmo_d   = tmo_q;
    fwd_d   = fwd_q;
    drop_d  = drop_q;
    tout_d  = tout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_sof) begin
          if (in_eof) begin
            // Single-byte frame: nothing to look up.
            state_d = ST_RESULT;
            fwd_d   = 4'd0;
            drop_d  = 1'b1;
            tout_d  = 1'b0;
          end else begin
            state_d = ST_PARSE;
          end
        end
      end

      ST_PARSE: begin
        if (in_valid && in_sof) begin
          // A new sof abandons the frame being parsed without a result.
          if (in_eof) begin
            state_d = ST_RESULT;
            fwd_d   = 4'd0;
            drop_d  = 1'b1;
            tout_d  = 1'b0;
          end
        end else if (in_valid && in_eof) begin
          if (cnt_q < LAST_KEY_BYTE) begin
            state_d = ST_RESULT;
            fwd_d   = 4'd0;
            drop_d  = 1'b1;
            tout_d  = 1'b0;
          end else if (etype_q != ETYPE_IPV4) begin
            // The ethertype was complete long before eof, so etype_q is final.
            state_d = ST_RESULT;
            fwd_d   = FLOOD_MASK;
            drop_d  = 1'b0;
            tout_d  = 1'b0;
          end else begin
            // The eof byte may itself be the last dst IP byte, so the key is
            // built from the next-cycle capture values.
            state_d = ST_REQ;
            key_d   = {PORT_ID, mac_d, sip_d, dip_d};
          end
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
        tmo_d   = TMO_LOAD;
      end

      ST_WAIT: begin
        if (of_lookup_ack) begin
          // Ack wins over a timeout expiring in the same cycle.
          state_d = ST_RESULT;
          fwd_d   = of_lookup_fwd_port;
          drop_d  = of_lookup_err || (of_lookup_fwd_port == 4'd0);
          tout_d  = 1'b0;
        end else if (tmo_q <= 8'd1) begin
          // Last waiting cycle: the counter would reach zero now.
          state_d = ST_RESULT;
          tmo_d   = 8'd0;
          fwd_d   = 4'd0;
          drop_d  = 1'b1;
          tout_d  = 1'b1;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end

      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    of_lookup_req  = (state_q == ST_REQ);
    of_lookup_data = key_q;
    res_valid      = (state_q == ST_RESULT);
    res_fwd_port   = fwd_q;
    res_drop       = drop_q;
    res_timeout    = tout_q;
    dbg_state      = state_q;
  end

`ifdef LOOKUPFLOW_REQ_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? (v + 16'd1) : v;
  endfunction

  logic [15:0] st_lookup_q, st_lookup_d;
  logic [15:0] st_err_q, st_err_d;
  logic [15:0] st_tmo_q, st_tmo_d;
  logic [15:0] st_ovr_q, st_ovr_d;
  logic        ev_lookup, ev_err, ev_tmo, ev_ovr;

  always_comb begin
    ev_lookup   = (state_q == ST_REQ);
    ev_err      = (state_q == ST_WAIT) && of_lookup_ack && of_lookup_err;
    ev_tmo      = (state_q == ST_WAIT) && !of_lookup_ack && (tmo_q <= 8'd1);
    // A sof seen while a lookup or result is outstanding is an overrun.
    ev_ovr      = in_valid && in_sof &&
                  ((state_q == ST_REQ) || (state_q == ST_WAIT) ||
                   (state_q == ST_RESULT));
    st_lookup_d = sat_inc(st_lookup_q, ev_lookup);
    st_err_d    = sat_inc(st_err_q, ev_err);
    st_tmo_d    = sat_inc(st_tmo_q, ev_tmo);
    st_ovr_d    = sat_inc(st_ovr_q, ev_ovr);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_lookup_q <= '0;
      st_err_q    <= '0;
      st_tmo_q    <= '0;
      st_ovr_q    <= '0;
    end else begin
      st_lookup_q <= st_lookup_d;
      st_err_q    <= st_err_d;
      st_tmo_q    <= st_tmo_d;
      st_ovr_q    <= st_ovr_d;
    end
  end

  assign stat_lookup  = st_lookup_q;
  assign stat_err     = st_err_q;
  assign stat_timeout = st_tmo_q;
  assign stat_overrun = st_ovr_q;
`endif

endmodule

// File: doc/lookupflow_req.md
Name: lookupflow_req

Overview:
- Initiator side of the of_lookup request/ack interface; the lookupflow responder sits on the other end.
- Sits between a port's 8-bit RX byte stream and the forwarding stage.
- Parses Ethernet/IPv4 header bytes per frame and builds the 116-bit lookup key.
- Issues a single-cycle lookup request, waits for ack (with timeout), and presents the forwarding decision through a valid/ready result handshake.

Parameters:
- PORT_ID, 4'h0: ingress port number placed in key bits [115:112].
- TIMEOUT, 16: cycles to wait for of_lookup_ack after the request pulse; legal range 1..255.
- FLOOD_MASK, 4'b1111: forwarding mask used for non-IPv4 frames.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte valid.
- in_sof  in  1  first byte of frame (qualified by in_valid).
- in_eof  in  1  last byte of frame (qualified by in_valid).
- in_data  in  8  frame byte (byte 0 = first DA byte).
- of_lookup_req  out  1  lookup request pulse.
- of_lookup_data  out  116  key: [115:112] port, [111:64] src MAC, [63:32] src IP, [31:0] dst IP.
- of_lookup_ack  in  1  lookup done.
- of_lookup_err  in  1  lookup error (valid with ack).
- of_lookup_fwd_port  in  4  forwarding mask (valid with ack).
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_fwd_port  out  4  forwarding mask.
- res_drop  out  1  frame is to be dropped.
- res_timeout  out  1  drop caused by lookup timeout.

Behaviour:
- Async reset (sys_rst_n low): all outputs 0, FSM in IDLE, byte counter 0.
- Byte counter, 11 bits, saturating at 2047:
  - Cleared to 1 on in_valid&in_sof; increments on each in_valid.
  - Bytes 6..11 capture src MAC; 12..13 capture ethertype; 26..29 capture src IP; 30..33 capture dst IP. Capture is MSB-first.
- FSM states: IDLE, PARSE, REQ, WAIT, RESULT.
- IDLE:
  - in_valid&in_sof goes to PARSE.
  - in_sof&in_eof together (single-byte frame) goes to RESULT with drop=1.
- PARSE, on in_valid&in_eof, classification:
  - Byte count < 34: RESULT, drop=1, fwd=0.
  - Ethertype != 16'h0800: RESULT, drop=0, fwd=FLOOD_MASK; no request is issued.
  - Otherwise: REQ.
- In-band sof while in PARSE: restart parsing; the earlier frame is discarded with no result.
- REQ (exactly one cycle):
  - of_lookup_req=1; of_lookup_data is driven with the key and held stable until the next frame's REQ.
  - Always goes to WAIT; load timeout counter with TIMEOUT.
- WAIT:
  - of_lookup_ack sampled high → RESULT with fwd=of_lookup_fwd_port and drop=of_lookup_err.
  - A returned mask of 0 with err=0 also sets drop=1.
  - Otherwise decrement the counter; at 0 → RESULT, drop=1, timeout=1, fwd=0.
  - Ack takes priority over timeout in the same cycle.
  - Minimum latency: eof byte at cycle N, req at N+1, ack at N+2, res_valid at N+3.
- RESULT:
  - res_valid=1; res_* held stable until res_valid&res_ready, then IDLE.
  - res_valid drops in the cycle after acceptance.
- Frames whose sof arrives in REQ, WAIT or RESULT are ignored entirely (overrun); they produce no request and no result.
- of_lookup_ack outside WAIT is ignored.
- Reset asserted mid-lookup: return to IDLE immediately. A late ack after reset release is ignored.

Optional Feature:
- Macro LOOKUPFLOW_REQ_STATS_EN.
- Defined: adds outputs stat_lookup, stat_err, stat_timeout, stat_overrun, each 16 bits.
  - Counters saturate at 16'hFFFF and reset to 0.
  - stat_lookup increments on each request pulse.
  - stat_err increments on ack with err.
  - stat_timeout increments on timeout.
  - stat_overrun increments on each ignored sof.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- 60-byte IPv4 frame, PORT_ID=2, src MAC 40:6c:8f:37:f1:f8, src IP 10.0.0.200, dst IP 10.0.0.3; responder stub acks 1 cycle after req with fwd 4'b0100 → req one cycle after eof; of_lookup_data={4'h2,48'h406c8f37f1f8,32'h0A0000C8,32'h0A000003}; res_valid at eof+3 with fwd=4'b0100, drop=0.
- Ethertype 16'h0806 frame → no req; res_valid with fwd=4'b1111, drop=0.
- 20-byte IPv4 frame → no req; res drop=1, fwd=0.
- TIMEOUT=16, stub never acks → res_valid 17 cycles after req; drop=1, timeout=1. Ack arriving later in IDLE causes no change.
- res_ready held low for 10 cycles while a second frame arrives → res_* stable throughout; second frame produces no req; stat_overrun=1 when the macro is defined. Then a third frame is processed normally.
- Stub acks with err=1, fwd=0 → drop=1, timeout=0. Assert sys_rst_n low during WAIT on a later frame → all outputs 0 immediately, FSM in IDLE.
